// File: rtl/moving_average_pkg.sv
// Shared types and sizing helpers for the stereo moving-average filter.
//   state_e   : handshake FSM states
//   depth_of  : averaging window length for a given log2 depth
//   sum_w_of  : running-sum width that cannot overflow for a full window
package moving_average_pkg;

  typedef enum logic [1:0] {
    WAIT    = 2'd0,
    CAPTURE = 2'd1,
    UPDATE  = 2'd2,
    OUTPUT  = 2'd3
  } state_e;

  localparam int unsigned DEFAULT_DATA_W     = 24;
  localparam int unsigned DEFAULT_LOG2_DEPTH = 3;

  function automatic int unsigned depth_of(input int unsigned log2_depth);
    return 32'd1 << log2_depth;
  endfunction

  function automatic int unsigned sum_w_of(input int unsigned data_w,
                                           input int unsigned log2_depth);
    return data_w + log2_depth;
  endfunction

endpackage

// File: rtl/sample_ring_buffer.sv
// Per-channel circular sample store: DEPTH x DATA_W, synchronous write and
// asynchronous read, both at the shared pointer.
//   clk       : system clock
//   wr_en     : write wr_data at ptr on the rising edge
//   ptr       : current slot (oldest sample once the window is full)
//   wr_data   : sample to store
//   rd_data_c : combinational contents of slot ptr
module sample_ring_buffer
  import moving_average_pkg::*;
#(
  parameter int unsigned DATA_W     = DEFAULT_DATA_W,
  parameter int unsigned LOG2_DEPTH = DEFAULT_LOG2_DEPTH
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [LOG2_DEPTH-1:0] ptr,
  input  logic [DATA_W-1:0]     wr_data,
  output logic [DATA_W-1:0]     rd_data_c
);

  localparam int unsigned DEPTH = depth_of(LOG2_DEPTH);

  // No reset: stale contents are masked by the fill count in the top level.
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[ptr] <= wr_data;
  end

  assign rd_data_c = mem[ptr];

endmodule

// File: rtl/moving_average_filter.sv
// Stereo moving-average low-pass filter between the codec ADC and DAC FIFOs.
// Averages the last 2^LOG2_DEPTH samples per channel with a running sum
// updated as new minus oldest.
//   clk, reset_n                  : clock, async active-low reset
//   read_ready, write_ready       : ADC FIFO has data / DAC FIFO has room
//   readdata_left/right           : signed input samples
//   bypass                        : pass captured sample through (sampled in UPDATE)
//   read, write                   : one-cycle pop / push strobes
//   writedata_left/right          : signed filtered samples
module moving_average_filter
  import moving_average_pkg::*;
#(
  parameter int unsigned DATA_W     = DEFAULT_DATA_W,
  parameter int unsigned LOG2_DEPTH = DEFAULT_LOG2_DEPTH
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              read_ready,
  input  logic              write_ready,
  input  logic [DATA_W-1:0] readdata_left,
  input  logic [DATA_W-1:0] readdata_right,
  input  logic              bypass,
  output logic              read,
  output logic              write,
  output logic [DATA_W-1:0] writedata_left,
  output logic [DATA_W-1:0] writedata_right
);

  localparam int unsigned DEPTH  = depth_of(LOG2_DEPTH);
  localparam int unsigned SUM_W  = sum_w_of(DATA_W, LOG2_DEPTH);
  localparam int unsigned FILL_W = LOG2_DEPTH + 1;

  state_e state, state_next;
  logic   read_next, write_next;

  logic [DATA_W-1:0]     cap_l, cap_r;
  logic [LOG2_DEPTH-1:0] ptr;
  logic [FILL_W-1:0]     fill;
  logic signed [SUM_W-1:0] sum_l, sum_r;

  logic [DATA_W-1:0]       old_l_raw, old_r_raw;
  logic                    full;
  logic signed [SUM_W-1:0] new_l, new_r, oldest_l, oldest_r;
  logic signed [SUM_W-1:0] sum_next_l, sum_next_r;
  logic [DATA_W-1:0]       avg_l, avg_r;

  // Next-state and strobe decode; strobes are registered from the next state.
  always_comb begin
    state_next = state;
    read_next  = 1'b0;
    write_next = 1'b0;
    case (state)
      WAIT: begin
        if (read_ready && write_ready) begin
          state_next = CAPTURE;
          read_next  = 1'b1;
        end
      end
      CAPTURE: state_next = UPDATE;
      UPDATE: begin
        state_next = OUTPUT;
        write_next = 1'b1;
      end
      OUTPUT:  state_next = WAIT;
      default: state_next = WAIT;
    endcase
  end

  sample_ring_buffer #(.DATA_W(DATA_W), .LOG2_DEPTH(LOG2_DEPTH)) u_ring_left (
    .clk       (clk),
    .wr_en     (state == UPDATE),
    .ptr       (ptr),
    .wr_data   (cap_l),
    .rd_data_c (old_l_raw)
  );

  sample_ring_buffer #(.DATA_W(DATA_W), .LOG2_DEPTH(LOG2_DEPTH)) u_ring_right (
    .clk       (clk),
    .wr_en     (state == UPDATE),
    .ptr       (ptr),
    .wr_data   (cap_r),
    .rd_data_c (old_r_raw)
  );

  // Running-sum datapath; the oldest slot only counts once the window is full.
  always_comb begin
    full       = (fill == FILL_W'(DEPTH));
    new_l      = {{LOG2_DEPTH{cap_l[DATA_W-1]}}, cap_l};
    new_r      = {{LOG2_DEPTH{cap_r[DATA_W-1]}}, cap_r};
    oldest_l   = full ? {{LOG2_DEPTH{old_l_raw[DATA_W-1]}}, old_l_raw} : '0;
    oldest_r   = full ? {{LOG2_DEPTH{old_r_raw[DATA_W-1]}}, old_r_raw} : '0;
    sum_next_l = sum_l + new_l - oldest_l;
    sum_next_r = sum_r + new_r - oldest_r;
    avg_l      = DATA_W'(sum_next_l >>> LOG2_DEPTH);
    avg_r      = DATA_W'(sum_next_r >>> LOG2_DEPTH);
  end

  // State, strobes, counters, sums and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= WAIT;
      read            <= 1'b0;
      write           <= 1'b0;
      cap_l           <= '0;
      cap_r           <= '0;
      ptr             <= '0;
      fill            <= '0;
      sum_l           <= '0;
      sum_r           <= '0;
      writedata_left  <= '0;
      writedata_right <= '0;
    end else begin
      state <= state_next;
      read  <= read_next;
      write <= write_next;
      if (state == CAPTURE) begin
        cap_l <= readdata_left;
        cap_r <= readdata_right;
      end
      if (state == UPDATE) begin
        sum_l           <= sum_next_l;
        sum_r           <= sum_next_r;
        ptr             <= ptr + LOG2_DEPTH'(1);
        if (!full) fill <= fill + FILL_W'(1);
        writedata_left  <= bypass ? cap_l : avg_l;
        writedata_right <= bypass ? cap_r : avg_r;
      end
    end
  end

endmodule

// File: tb/tb_moving_average_filter.sv
// Directed bench for moving_average_filter: one instance with a 4-deep
// window and one with the default 8-deep window share all stimulus.
module tb_moving_average_filter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n, read_ready, write_ready, bypass;
  logic signed [23:0] rd_l, rd_r;
  logic read2, write2, read3, write3;
  logic signed [23:0] wd2_l, wd2_r, wd3_l, wd3_r;

  int vectors     = 0;
  int miscompares = 0;

  moving_average_filter #(.DATA_W(24), .LOG2_DEPTH(2)) dut2 (
    .clk             (clk),
    .reset_n         (reset_n),
    .read_ready      (read_ready),
    .write_ready     (write_ready),
    .readdata_left   (rd_l),
    .readdata_right  (rd_r),
    .bypass          (bypass),
    .read            (read2),
    .write           (write2),
    .writedata_left  (wd2_l),
    .writedata_right (wd2_r)
  );

  moving_average_filter dut3 (
    .clk             (clk),
    .reset_n         (reset_n),
    .read_ready      (read_ready),
    .write_ready     (write_ready),
    .readdata_left   (rd_l),
    .readdata_right  (rd_r),
    .bypass          (bypass),
    .read            (read3),
    .write           (write3),
    .writedata_left  (wd3_l),
    .writedata_right (wd3_r)
  );

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    read_ready = 1'b0;
    write_ready = 1'b0;
    bypass = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // One full transaction; checks strobe timing and returns both DUTs' outputs.
  task automatic run_sample(input logic signed [23:0] l, input logic signed [23:0] r,
                            input logic byp,
                            output logic signed [23:0] o2l, output logic signed [23:0] o2r,
                            output logic signed [23:0] o3l, output logic signed [23:0] o3r);
    int cycles;
    @(negedge clk);
    rd_l = l;
    rd_r = r;
    bypass = byp;
    read_ready = 1'b1;
    write_ready = 1'b1;
    @(negedge clk);
    read_ready = 1'b0;
    write_ready = 1'b0;
    vectors++;
    if (read2 !== 1'b1 || write2 !== 1'b0) begin
      miscompares++;
      $display("FAIL sample_read_strobe: read=%b write=%b, want read=1 write=0", read2, write2);
    end
    cycles = 1;
    while (write2 !== 1'b1 && cycles < 8) begin
      @(negedge clk);
      cycles++;
    end
    vectors++;
    if (cycles != 3) begin
      miscompares++;
      $display("FAIL sample_write_latency: write seen after %0d cycles, want 3", cycles);
    end
    o2l = wd2_l;
    o2r = wd2_r;
    o3l = wd3_l;
    o3r = wd3_r;
    @(negedge clk);
    vectors++;
    if (write2 !== 1'b0 || read2 !== 1'b0) begin
      miscompares++;
      $display("FAIL sample_strobe_end: read=%b write=%b, want 0 0", read2, write2);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    read_ready = 1'b1;
    write_ready = 1'b1;
    bypass = 1'b0;
    rd_l = 24'sd5;
    rd_r = 24'sd5;
    #1;
    vectors++;
    if (read2 !== 1'b0 || write2 !== 1'b0 || wd2_l !== 24'sd0 || wd2_r !== 24'sd0) begin
      miscompares++;
      $display("FAIL reset_dut2: read=%b write=%b l=%0d r=%0d, want all 0", read2, write2, wd2_l, wd2_r);
    end
    vectors++;
    if (read3 !== 1'b0 || write3 !== 1'b0 || wd3_l !== 24'sd0 || wd3_r !== 24'sd0) begin
      miscompares++;
      $display("FAIL reset_dut3: read=%b write=%b l=%0d r=%0d, want all 0", read3, write3, wd3_l, wd3_r);
    end
    repeat (3) begin
      @(negedge clk);
      vectors++;
      if (read2 !== 1'b0 || write2 !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_hold_strobes: read=%b write=%b, want 0 0", read2, write2);
      end
    end
    read_ready = 1'b0;
    write_ready = 1'b0;
    reset_n = 1'b1;
  endtask

  task automatic test_constant();
    int exp_l [6] = '{25, 50, 75, 100, 100, 100};
    int exp_r [6] = '{-2, -4, -6, -8, -8, -8};
    logic signed [23:0] o2l, o2r, o3l, o3r;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      run_sample(24'sd100, -24'sd8, 1'b0, o2l, o2r, o3l, o3r);
      vectors++;
      if (o2l !== 24'(exp_l[i]) || o2r !== 24'(exp_r[i])) begin
        miscompares++;
        $display("FAIL constant[%0d]: got l=%0d r=%0d, want l=%0d r=%0d", i, o2l, o2r, exp_l[i], exp_r[i]);
      end
    end
  endtask

  // Continues from test_constant: zeros flush the window, then a step.
  task automatic test_step();
    int in_l  [10] = '{0, 0, 0, 0, 400, 400, 400, 400, 0, 0};
    int exp_l [10] = '{75, 50, 25, 0, 100, 200, 300, 400, 300, 200};
    logic signed [23:0] o2l, o2r, o3l, o3r;
    for (int i = 0; i < 10; i++) begin
      run_sample(24'(in_l[i]), 24'sd0, 1'b0, o2l, o2r, o3l, o3r);
      vectors++;
      if (o2l !== 24'(exp_l[i])) begin
        miscompares++;
        $display("FAIL step[%0d]: got %0d, want %0d", i, o2l, exp_l[i]);
      end
    end
  endtask

  task automatic test_bypass();
    int exp_l [6] = '{25, 50, 100, 100, 100, 100};
    logic signed [23:0] o2l, o2r, o3l, o3r;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      run_sample(24'sd100, 24'sd40, (i == 2), o2l, o2r, o3l, o3r);
      vectors++;
      if (o2l !== 24'(exp_l[i])) begin
        miscompares++;
        $display("FAIL bypass[%0d]: got %0d, want %0d", i, o2l, exp_l[i]);
      end
    end
    vectors++;
    if (o2r !== 24'sd40) begin
      miscompares++;
      $display("FAIL bypass_right: got %0d, want 40", o2r);
    end
  endtask

  task automatic test_wait_hold();
    do_reset();
    @(negedge clk);
    rd_l = 24'sd0;
    rd_r = 24'sd0;
    read_ready = 1'b1;
    write_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      vectors++;
      if (read2 !== 1'b0 || write2 !== 1'b0) begin
        miscompares++;
        $display("FAIL hold_strobes: read=%b write=%b, want 0 0", read2, write2);
      end
    end
    write_ready = 1'b1;
    // Readies stay high through the transaction; they must be ignored.
    @(negedge clk);
    vectors++;
    if (read2 !== 1'b1) begin
      miscompares++;
      $display("FAIL hold_read_rise: read=%b, want 1", read2);
    end
    @(negedge clk);
    vectors++;
    if (read2 !== 1'b0 || write2 !== 1'b0) begin
      miscompares++;
      $display("FAIL hold_update: read=%b write=%b, want 0 0", read2, write2);
    end
    @(negedge clk);
    vectors++;
    if (read2 !== 1'b0 || write2 !== 1'b1) begin
      miscompares++;
      $display("FAIL hold_write_rise: read=%b write=%b, want 0 1", read2, write2);
    end
    @(negedge clk);
    read_ready = 1'b0;
    write_ready = 1'b0;
    vectors++;
    if (read2 !== 1'b0 || write2 !== 1'b0) begin
      miscompares++;
      $display("FAIL hold_write_fall: read=%b write=%b, want 0 0", read2, write2);
    end
  endtask

  task automatic test_reset_mid();
    logic signed [23:0] o2l, o2r, o3l, o3r;
    do_reset();
    run_sample(24'sd100, 24'sd100, 1'b0, o2l, o2r, o3l, o3r);
    vectors++;
    if (o2l !== 24'sd25) begin
      miscompares++;
      $display("FAIL midreset_pre: got %0d, want 25", o2l);
    end
    @(negedge clk);
    read_ready = 1'b1;
    write_ready = 1'b1;
    @(negedge clk);
    read_ready = 1'b0;
    write_ready = 1'b0;
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    vectors++;
    if (wd2_l !== 24'sd0 || wd2_r !== 24'sd0 || read2 !== 1'b0 || write2 !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_clear: l=%0d r=%0d read=%b write=%b, want all 0", wd2_l, wd2_r, read2, write2);
    end
    @(negedge clk);
    vectors++;
    if (write2 !== 1'b0 || read2 !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_no_strobe: read=%b write=%b, want 0 0", read2, write2);
    end
    reset_n = 1'b1;
    run_sample(24'sd200, 24'sd200, 1'b0, o2l, o2r, o3l, o3r);
    vectors++;
    if (o2l !== 24'sd50 || o2r !== 24'sd50) begin
      miscompares++;
      $display("FAIL midreset_after: got l=%0d r=%0d, want 50 50", o2l, o2r);
    end
  endtask

  task automatic test_extremes();
    longint hist [$];
    longint s;
    logic signed [23:0] smp, exp_v;
    logic signed [23:0] o2l, o2r, o3l, o3r;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      smp = (i < 8) ? -24'sd8388608 : 24'sd8388607;
      hist.push_back(longint'(smp));
      s = 0;
      for (int k = 0; k < 8; k++) begin
        if (hist.size() > k) s += hist[hist.size() - 1 - k];
      end
      exp_v = 24'(s >>> 3);
      run_sample(smp, smp, 1'b0, o2l, o2r, o3l, o3r);
      vectors++;
      if (o3l !== exp_v || o3r !== exp_v) begin
        miscompares++;
        $display("FAIL extreme[%0d]: got l=%0d r=%0d, want %0d", i, o3l, o3r, exp_v);
      end
    end
    vectors++;
    if (o3l !== 24'sd8388607) begin
      miscompares++;
      $display("FAIL extreme_final: got %0d, want 8388607", o3l);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_constant();
    test_step();
    test_bypass();
    test_wait_hold();
    test_reset_mid();
    test_extremes();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/moving_average_filter.md
# moving_average_filter

Parametrised stereo moving-average low-pass filter for the audio codec path, placed between the codec's ADC FIFO (readdata) and DAC FIFO (writedata). It averages the last 2^LOG2_DEPTH samples per channel using a circular sample buffer and a running sum. The sum is updated as new minus oldest, so cost does not grow with depth. It adds an explicit read/write strobe handshake, per-channel processing, warm-up handling and a runtime bypass mode.

## Interface
- DATA_W, 24, sample width, signed two's complement
- LOG2_DEPTH, 3, log2 of averaging window; DEPTH = 2^LOG2_DEPTH, legal range 1..8
- clk  input  1  system clock
- reset_n  input  1  asynchronous, active-low reset
- read_ready  input  1  codec ADC FIFO holds a sample for both channels
- write_ready  input  1  codec DAC FIFO has room for both channels
- readdata_left / readdata_right  input  DATA_W  signed input samples
- bypass  input  1  1 = pass the captured sample straight to the output; sampled in UPDATE
- read  output  1  one-cycle strobe; pops the ADC FIFO
- write  output  1  one-cycle strobe; pushes writedata to the DAC FIFO
- writedata_left / writedata_right  output  DATA_W  signed filtered samples, registered

## Operation
- FSM states:
  - WAIT: idle; leaves when read_ready && write_ready.
  - CAPTURE: read=1; both channels latched at the end of the cycle.
  - UPDATE: buffer and sum update.
  - OUTPUT: write=1; writedata stable.
  - Transitions: WAIT→CAPTURE→UPDATE→OUTPUT→WAIT.
- UPDATE, per channel:
  - oldest = buffer[ptr] if fill == DEPTH, else 0.
  - sum <= sum + new − oldest.
  - buffer[ptr] <= new.
  - ptr <= ptr + 1, wrapping modulo DEPTH.
  - fill saturates at DEPTH.
- Running sum width is DATA_W+LOG2_DEPTH, signed; it never overflows.
- Output is sum_next >>> LOG2_DEPTH (arithmetic shift, floor toward −∞), truncated to DATA_W.
- Bypass: writedata = captured sample unchanged. Buffer, sum, ptr and fill still update, so leaving bypass gives a correct average immediately.
- Warm-up: until DEPTH samples have been seen, missing samples count as 0. The output ramps up; it is not renormalised.
- Channels share ptr, fill and FSM and are processed in parallel.

## Timing
- Reset (asynchronous assert, synchronous release edge):
  - state=WAIT; read=0, write=0, writedata_*=0.
  - sum=0, ptr=0, fill=0.
  - Buffer contents are don't-care, because fill gates them.
- Acceptance occurs at the first clock edge in WAIT with both readies high.
- read is high during the following cycle only. Latency from the acceptance edge to write high is 3 cycles, and write is high for 1 cycle.
- Maximum throughput is one sample pair per 4 cycles.
- A ready deasserting after acceptance does not abort the transaction: CAPTURE, UPDATE and OUTPUT always complete.
- Readies are ignored outside WAIT.
- The bypass value is taken only in UPDATE; changing it mid-transaction affects the next sample.
- Reset asserted in any state returns to WAIT immediately. No strobe may glitch high during reset.
- writedata holds its value between OUTPUT cycles.

## Structure
- Package moving_average_pkg:
  - state enum (WAIT, CAPTURE, UPDATE, OUTPUT)
  - localparam helpers for DEPTH and SUM_W
- Sub-module sample_ring_buffer, instantiated once per channel. It holds the DEPTH×DATA_W storage with a synchronous write port and an asynchronous read at ptr. Parameters: DATA_W, LOG2_DEPTH.
- The top level holds the FSM, ptr/fill counters, the two running sums and the output registers.

## Test plan
- LOG2_DEPTH=2, constant left=100, right=−8 for 6 samples. Left outputs 25,50,75,100,100,100; right outputs −2,−4,−6,−8,−8,−8.
- LOG2_DEPTH=2, after 4 samples of 0, apply the step 400,400,400,400,0,0. Outputs 100,200,300,400,300,200. This checks wrap-around and subtraction of the oldest sample.
- Bypass=1 on the 3rd of 5 constant-100 samples (LOG2_DEPTH=2). Outputs 25,50,100,100,100. After bypass returns to 0, the next output is 100.
- Hold write_ready=0 with read_ready=1. read and write stay 0 and the state stays WAIT. Raise write_ready: read rises one cycle later and write 3 cycles after acceptance.
- Assert reset_n=0 during UPDATE. Outputs, sum and fill clear asynchronously. The first sample after release (200, LOG2_DEPTH=2) outputs 50.
- Default DEPTH=8 with extremes (−2^23 ×8, then +2^23−1 ×8). Outputs −2^23 and then 2^23−1 with no overflow, and intermediate values match a reference model.
